// File: rtl/runner_ctrl.sv
// rtl/runner_ctrl.sv - player run/jump/fall physics and wall-collision control for the terrain runner
module runner_ctrl #(
    parameter int PX     = 96,
    parameter int PW     = 16,
    parameter int BASE_Y = 350,
    parameter int JUMP_V = 12,
    parameter int GRAV   = 1,
    parameter int VMAX   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       jump,
    input  logic [9:0] x_1,
    input  logic [6:0] left_height,
    input  logic [6:0] height_1,
    input  logic [6:0] height_2,
    input  logic [6:0] height_3,
    output logic [8:0] player_y,
    output logic [1:0] state,
    output logic       jumping,
    output logic       game_over
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_AIR  = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    localparam logic [10:0] P_BACK  = 11'(PX);
    localparam logic [10:0] P_FRONT = 11'(PX + PW - 1);
    localparam logic [8:0]  Y_RESET = 9'(BASE_Y - 10);
    localparam logic [8:0]  Y_BASE  = 9'(BASE_Y);

    localparam logic signed [5:0] V_JUMP = 6'(GRAV - JUMP_V);
    localparam logic signed [5:0] V_GRAV = 6'(GRAV);
    localparam logic signed [5:0] V_MAX  = 6'(VMAX);

    // Column lookup in 11 bits so x_1+128 never wraps.
    function automatic logic [6:0] lookup(
        input logic [10:0] p,
        input logic [9:0]  x1,
        input logic [6:0]  hl,
        input logic [6:0]  h1,
        input logic [6:0]  h2,
        input logic [6:0]  h3
    );
        logic [10:0] x1w;
        x1w = {1'b0, x1};
        if (p < x1w)
            lookup = hl;
        else if (p < x1w + 11'd64)
            lookup = h1;
        else if (p < x1w + 11'd128)
            lookup = h2;
        else
            lookup = h3;
    endfunction

    logic              jump_s1;
    logic              jump_s2;
    logic              jump_prev;
    logic              jump_pending;
    logic              jump_rise;
    logic              jump_req;
    logic signed [5:0] vel;

    logic [6:0]        hb;
    logic [6:0]        hf;
    logic [6:0]        hmax;
    logic [8:0]        front_top;
    logic [8:0]        support_top;
    logic signed [9:0] ny_raw;
    logic [8:0]        ny;
    logic signed [5:0] vel_inc;
    logic signed [5:0] vel_next;

    always_comb begin
        hb          = lookup(P_BACK,  x_1, left_height, height_1, height_2, height_3);
        hf          = lookup(P_FRONT, x_1, left_height, height_1, height_2, height_3);
        hmax        = (hb > hf) ? hb : hf;
        front_top   = Y_BASE - {2'b00, hf};
        support_top = Y_BASE - {2'b00, hmax};
    end

    // Falling step: ny saturates at the top of the screen.
    always_comb begin
        ny_raw   = $signed({1'b0, player_y}) + {{4{vel[5]}}, vel};
        ny       = ny_raw[9] ? 9'd0 : ny_raw[8:0];
        vel_inc  = vel + V_GRAV;
        vel_next = (vel_inc > V_MAX) ? V_MAX : vel_inc;
    end

    assign jump_rise = jump_s2 & ~jump_prev;
    // An edge arriving in the tick cycle itself is consumed by that tick.
    assign jump_req  = jump_pending | jump_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jump_s1      <= 1'b0;
            jump_s2      <= 1'b0;
            jump_prev    <= 1'b0;
            jump_pending <= 1'b0;
            state        <= S_IDLE;
            player_y     <= Y_RESET;
            vel          <= 6'sd0;
        end else begin
            jump_s1   <= jump;
            jump_s2   <= jump_s1;
            jump_prev <= jump_s2;

            if (tick)
                jump_pending <= 1'b0;
            else if (jump_rise)
                jump_pending <= 1'b1;

            if (!start) begin
                state    <= S_IDLE;
                vel      <= 6'sd0;
                player_y <= support_top;
            end else if (tick) begin
                case (state)
                    S_IDLE: begin
                        state    <= S_RUN;
                        player_y <= support_top;
                    end
                    S_RUN: begin
                        if (front_top < player_y) begin
                            state <= S_DEAD;
                        end else if (jump_req) begin
                            state    <= S_AIR;
                            player_y <= player_y - 9'(JUMP_V);
                            vel      <= V_JUMP;
                        end else if (support_top > player_y) begin
                            state <= S_AIR;
                            vel   <= 6'sd0;
                        end else begin
                            player_y <= support_top;
                        end
                    end
                    S_AIR: begin
                        if (!vel[5] && (ny >= support_top)) begin
                            state    <= S_RUN;
                            player_y <= support_top;
                            vel      <= 6'sd0;
                        end else if (front_top < ny) begin
                            state <= S_DEAD;
                        end else begin
                            player_y <= ny;
                            vel      <= vel_next;
                        end
                    end
                    default: begin
                        state <= S_DEAD;
                    end
                endcase
            end
        end
    end

    assign jumping   = (state == S_AIR);
    assign game_over = (state == S_DEAD);

endmodule

// File: tb/tb_runner_ctrl.sv
// tb/tb_runner_ctrl.sv - scoreboard bench for runner_ctrl physics, collisions and jump handling
module tb_runner_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       jump;
    logic [9:0] x_1;
    logic [6:0] left_height;
    logic [6:0] height_1;
    logic [6:0] height_2;
    logic [6:0] height_3;
    logic [8:0] player_y;
    logic [1:0] state;
    logic       jumping;
    logic       game_over;

    typedef struct packed {
        logic [1:0] st;
        logic [8:0] y;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    runner_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .jump(jump),
        .x_1(x_1), .left_height(left_height), .height_1(height_1),
        .height_2(height_2), .height_3(height_3), .player_y(player_y),
        .state(state), .jumping(jumping), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick_once;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_jump;
        jump = 1'b1;
        repeat (3) @(negedge clk);
        jump = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_heights(input logic [6:0] h);
        left_height = h;
        height_1    = h;
        height_2    = h;
        height_3    = h;
    endtask

    task automatic test_reset;
        reset = 1'b0; tick = 1'b0; start = 1'b0; jump = 1'b0; x_1 = 10'd0;
        set_heights(7'd10);
        repeat (2) @(negedge clk);
        vectors++;
        if ({state, player_y, jumping, game_over} !== {2'd0, 9'd340, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got st=%0d y=%0d jmp=%0b go=%0b, want st=0 y=340 jmp=0 go=0",
                     state, player_y, jumping, game_over);
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        q.push_back('{st: 2'd1, y: 9'd340});
        tick_once();
        e = q.pop_front();
        vectors++;
        if ({state, player_y, game_over} !== {e.st, e.y, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_to_run: got st=%0d y=%0d go=%0b, want st=%0d y=%0d go=0",
                     state, player_y, game_over, e.st, e.y);
        end
    endtask

    task automatic test_jump;
        int ey = 340;
        int ev = 0;
        int ny;
        logic [1:0] est = 2'd1;
        pulse_jump();
        for (int k = 1; k <= 25; k++) begin
            if (est == 2'd1) begin
                ey = ey - 12; ev = -11; est = 2'd2;
            end else begin
                ny = ey + ev;
                if (ev >= 0 && ny >= 340) begin
                    est = 2'd1; ey = 340; ev = 0;
                end else begin
                    ey = ny;
                    ev = (ev + 1 > 15) ? 15 : ev + 1;
                end
            end
            q.push_back('{st: est, y: 9'(ey)});
            tick_once();
            e = q.pop_front();
            vectors++;
            if ({state, player_y, jumping} !== {e.st, e.y, e.st == 2'd2}) begin
                miscompares++;
                $display("FAIL jump_tick%0d: got st=%0d y=%0d jmp=%0b, want st=%0d y=%0d jmp=%0b",
                         k, state, player_y, jumping, e.st, e.y, e.st == 2'd2);
            end
            if (k == 12) begin
                vectors++;
                if (player_y !== 9'd262) begin
                    miscompares++;
                    $display("FAIL jump_peak: got y=%0d, want y=262", player_y);
                end
            end
        end
    endtask

    task automatic test_wall;
        x_1 = 10'd0;
        height_2 = 7'd40;
        for (int k = 0; k < 2; k++) begin
            q.push_back('{st: 2'd3, y: 9'd340});
            tick_once();
            e = q.pop_front();
            vectors++;
            if ({state, player_y, game_over} !== {e.st, e.y, 1'b1}) begin
                miscompares++;
                $display("FAIL wall_dead%0d: got st=%0d y=%0d go=%0b, want st=3 y=340 go=1",
                         k, state, player_y, game_over);
            end
        end
        start = 1'b0;
        q.push_back('{st: 2'd0, y: 9'd310});
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if ({state, player_y, game_over} !== {e.st, e.y, 1'b0}) begin
            miscompares++;
            $display("FAIL wall_exit: got st=%0d y=%0d go=%0b, want st=0 y=310 go=0",
                     state, player_y, game_over);
        end
    endtask

    task automatic test_lookup;
        logic [9:0] xs[4]  = '{10'd32, 10'd33, 10'd47, 10'd48};
        logic [6:0] h1s[4] = '{7'd30, 7'd30, 7'd20, 7'd20};
        logic [6:0] h2s[4] = '{7'd20, 7'd20, 7'd30, 7'd30};
        logic [8:0] ys[4]  = '{9'd330, 9'd320, 9'd320, 9'd330};
        start = 1'b0;
        set_heights(7'd0);
        for (int i = 0; i < 4; i++) begin
            x_1 = xs[i]; height_1 = h1s[i]; height_2 = h2s[i];
            q.push_back('{st: 2'd0, y: ys[i]});
            @(negedge clk);
            e = q.pop_front();
            vectors++;
            if ({state, player_y} !== {e.st, e.y}) begin
                miscompares++;
                $display("FAIL lookup_x%0d: got st=%0d y=%0d, want st=%0d y=%0d",
                         xs[i], state, player_y, e.st, e.y);
            end
        end
        x_1 = 10'd0;
    endtask

    task automatic test_drop;
        int ey = 310;
        int ev = 0;
        int ny;
        int n = 0;
        logic [1:0] est = 2'd2;
        start = 1'b0;
        set_heights(7'd40);
        @(negedge clk);
        start = 1'b1;
        q.push_back('{st: 2'd1, y: 9'd310});
        tick_once();
        set_heights(7'd10);
        q.push_back('{st: 2'd2, y: 9'd310});
        tick_once();
        for (int k = 0; k < 2; k++) begin
            e = q.pop_front();
            vectors++;
            if (k == 0) begin
                if ({2'd1, 9'd310} !== {e.st, e.y}) miscompares++;
            end else if ({state, player_y} !== {e.st, e.y}) begin
                miscompares++;
                $display("FAIL drop_start: got st=%0d y=%0d, want st=%0d y=%0d",
                         state, player_y, e.st, e.y);
            end
        end
        while (est == 2'd2 && n < 20) begin
            n++;
            ny = ey + ev;
            if (ev >= 0 && ny >= 340) begin
                est = 2'd1; ey = 340; ev = 0;
            end else begin
                ey = ny;
                ev = (ev + 1 > 15) ? 15 : ev + 1;
            end
            q.push_back('{st: est, y: 9'(ey)});
            tick_once();
            e = q.pop_front();
            vectors++;
            if ({state, player_y} !== {e.st, e.y}) begin
                miscompares++;
                $display("FAIL drop_fall%0d: got st=%0d y=%0d, want st=%0d y=%0d",
                         n, state, player_y, e.st, e.y);
            end
        end
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL drop_land_tick: got %0d fall ticks, want 9", n);
        end
    endtask

    task automatic test_back_to_back;
        int ey = 328;
        int ev = -11;
        int ny;
        int n = 0;
        logic [1:0] est = 2'd2;
        pulse_jump();
        pulse_jump();
        q.push_back('{st: 2'd2, y: 9'd328});
        tick_once();
        e = q.pop_front();
        vectors++;
        if ({state, player_y} !== {e.st, e.y}) begin
            miscompares++;
            $display("FAIL double_edge: got st=%0d y=%0d, want st=2 y=328", state, player_y);
        end
        pulse_jump();
        while (est == 2'd2 && n < 40) begin
            n++;
            ny = ey + ev;
            if (ev >= 0 && ny >= 340) begin
                est = 2'd1; ey = 340; ev = 0;
            end else begin
                ey = ny;
                ev = (ev + 1 > 15) ? 15 : ev + 1;
            end
            q.push_back('{st: est, y: 9'(ey)});
            tick_once();
            e = q.pop_front();
            vectors++;
            if ({state, player_y} !== {e.st, e.y}) begin
                miscompares++;
                $display("FAIL air_edge%0d: got st=%0d y=%0d, want st=%0d y=%0d",
                         n, state, player_y, e.st, e.y);
            end
        end
        q.push_back('{st: 2'd1, y: 9'd340});
        tick_once();
        e = q.pop_front();
        vectors++;
        if ({state, player_y} !== {e.st, e.y}) begin
            miscompares++;
            $display("FAIL stale_pending: got st=%0d y=%0d, want st=1 y=340", state, player_y);
        end
        jump = 1'b1;
        repeat (2) @(negedge clk);
        q.push_back('{st: 2'd2, y: 9'd328});
        tick_once();
        jump = 1'b0;
        e = q.pop_front();
        vectors++;
        if ({state, player_y} !== {e.st, e.y}) begin
            miscompares++;
            $display("FAIL edge_with_tick: got st=%0d y=%0d, want st=2 y=328", state, player_y);
        end
    endtask

    task automatic test_reset_mid_air;
        repeat (3) tick_once();
        vectors++;
        if ({state, player_y} !== {2'd2, 9'd298}) begin
            miscompares++;
            $display("FAIL pre_reset_air: got st=%0d y=%0d, want st=2 y=298", state, player_y);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({state, player_y, jumping} !== {2'd0, 9'd340, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got st=%0d y=%0d jmp=%0b, want st=0 y=340 jmp=0",
                     state, player_y, jumping);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q.push_back('{st: 2'd1, y: 9'd340});
        tick_once();
        e = q.pop_front();
        vectors++;
        if ({state, player_y} !== {e.st, e.y}) begin
            miscompares++;
            $display("FAIL reset_release: got st=%0d y=%0d, want st=1 y=340", state, player_y);
        end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_wall();
        test_lookup();
        test_drop();
        test_back_to_back();
        test_reset_mid_air();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
